uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Serial receive front end of the UART crypt system. Accepts the async uart_rx_in
//   line (8N1, LSB first, idle high), deserialises bytes by mid-bit sampling and
//   buffers them in a small first-word-fall-through FIFO. The menu/crypt logic in
//   modulul_principal consumes from this FIFO. Framing errors and overruns are flagged.
// PARAMETERS
//   CLKS_PER_BIT  10416  clk cycles per UART bit (100 MHz / 9600 baud); must be >= 8
//   FIFO_DEPTH    4      byte entries; power of two
//   ADDR_W        2      log2(FIFO_DEPTH)
// PORTS
//   clk         in   1  system clock, 100 MHz
//   rst_pin     in   1  synchronous, active-high reset
//   uart_rx_in  in   1  async serial input; idle = 1
//   rd_en       in   1  pop request; effective only when rd_valid = 1
//   rd_data     out  8  FIFO head byte; valid while rd_valid = 1
//   rd_valid    out  1  FIFO not empty
//   fifo_full   out  1  FIFO holds FIFO_DEPTH bytes
//   frame_err   out  1  one-cycle pulse: stop bit sampled 0
//   overrun     out  1  sticky: byte dropped because FIFO was full
// BEHAVIOUR
//   Reset: FSM = IDLE; bit counter, shift reg, pointers, count = 0; rd_valid, fifo_full,
//     frame_err, overrun = 0; rd_data = 0; both sync flops preset to 1 (no false start).
//   Reset mid-byte aborts the frame; the partial byte is never pushed.
//   Input: 2-flop synchroniser; FSM uses only the synchronised value rx_s.
//   FSM (one baud counter cnt, bit index idx 0..7):
//     IDLE  : rx_s = 0 -> START, cnt = 0.
//     START : at cnt = CLKS_PER_BIT/2-1 sample rx_s; 0 -> DATA, cnt = 0, idx = 0;
//             1 -> IDLE (glitch; no flag).
//     DATA  : at cnt = CLKS_PER_BIT-1 shift rx_s in at bit idx (LSB first), cnt = 0;
//             after idx 7 -> STOP.
//     STOP  : at cnt = CLKS_PER_BIT-1 sample rx_s; 1 -> push byte, -> IDLE;
//             0 -> frame_err = 1 for exactly one cycle, byte discarded, -> BREAK.
//     BREAK : wait for rx_s = 1, then -> IDLE (no restart during a held-low line).
//   Sampling points relative to the detected start edge: start at +CLKS/2,
//     data bit i at +CLKS/2 + (i+1)*CLKS, stop at +CLKS/2 + 9*CLKS.
//   Push latency: rd_valid and rd_data update on the cycle after the stop sample.
//   FIFO (FWFT): rd_data = mem[rd_ptr] combinationally from registered storage;
//     count 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
//     Pop: rd_en && rd_valid -> rd_ptr++; rd_en while empty is ignored (no underflow).
//     Push when not full -> write, wr_ptr++.
//     Push when full and no pop in the same cycle -> byte dropped, overrun <= 1.
//     Push and pop in the same cycle (any fill level, including full) -> both happen,
//     count unchanged, no overrun.
//   overrun clears on the next effective pop or on reset; if a drop and a pop fall in
//     the same cycle, no drop occurs (see previous rule).
//   fifo_full = (count == FIFO_DEPTH); rd_valid = (count != 0); both registered.
// TESTING (bench overrides CLKS_PER_BIT = 16, so bit period = 160 ns)
//   1 Send 0x53 ('S') 8N1 -> 1 cycle after stop sample rd_valid = 1, rd_data = 0x53,
//     frame_err never 1; pulse rd_en 1 cycle -> rd_valid = 0.
//   2 Drive uart_rx_in low for 4 clk then high -> no push, FSM back in IDLE,
//     frame_err = 0, rd_valid stays 0.
//   3 Send 0x41 with stop bit = 0, then hold low 3 bit times, then high -> exactly one
//     frame_err pulse, FIFO empty, next frame 0x42 is received correctly.
//   4 Send 0x01..0x05 with no reads -> fifo_full = 1 after 0x04, overrun = 1 after 0x05;
//     read 4 times -> 0x01,0x02,0x03,0x04 in order; overrun = 0 after the first pop.
//   5 Assert rst_pin for 1 cycle during data bit 3 of 0xA5 -> all outputs 0 next cycle,
//     no push; then send 0xA5 -> rd_data = 0xA5.
//   6 Fill FIFO with 0x10..0x13; send 0x14, asserting rd_en on the push cycle
//     -> overrun stays 0, fifo_full stays 1, read order 0x11,0x12,0x13,0x14.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small first-word-fall-through byte FIFO.
// Flags stop-bit framing errors and bytes dropped on a full FIFO.
//
// Ports:
//   clk        system clock
//   rst_pin    synchronous active-high reset
//   uart_rx_in asynchronous serial line, idle high
//   rd_en      pop request, honoured only while rd_valid is high
//   rd_data    FIFO head byte
//   rd_valid   FIFO not empty
//   fifo_full  FIFO holds FIFO_DEPTH bytes
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    sticky; a byte was dropped, cleared by the next pop
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic       clk,
  input  logic       rst_pin,
  input  logic       uart_rx_in,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1 =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser; both flops reset high so that
  // reset never looks like a start edge.
  logic sync1_q;
  logic rx_s_q;

  always_ff @(posedge clk) begin
    if (rst_pin) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  // Receive FSM
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             ferr_q, ferr_d;
  logic             push;

  always_ff @(posedge clk) begin
    if (rst_pin) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          // A high line at mid start bit was a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          // LSB first: after eight shifts bit 0 is at [0].
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Held-low line must release before a new frame.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FWFT FIFO
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              valid_q;
  logic              full_q;
  logic              ovr_q;
  logic              pop;
  logic              wr_ok;
  logic              drop;

  // A simultaneous pop frees the slot a full-FIFO
  // push needs, so nothing is dropped then.
  assign pop   = rd_en && valid_q;
  assign wr_ok = push && (!full_q || pop);
  assign drop  = push && full_q && !pop;

  always_comb begin
    count_d = count_q;
    if (wr_ok) count_d = count_d + (ADDR_W + 1)'(1);
    if (pop)   count_d = count_d - (ADDR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_pin) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_pin) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == DEPTH);
      if (drop)     ovr_q <= 1'b1;
      else if (pop) ovr_q <= 1'b0;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign rd_valid  = valid_q;
  assign fifo_full = full_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames in, byte queue
// model with overrun flag, directed and random scenarios.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_pin;
  logic       uart_rx_in;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       fifo_full;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4),
    .ADDR_W(2)
  ) dut (
    .clk(clk),
    .rst_pin(rst_pin),
    .uart_rx_in(uart_rx_in),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .fifo_full(fifo_full),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  int nvec = 0;
  int nerr = 0;
  int fe_cnt = 0;

  logic [7:0] q[$];
  logic       exp_ovr = 1'b0;

  always @(negedge clk)
    if (frame_err === 1'b1) fe_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: plain, 1: check push latency (FIFO empty),
  // 2: pop on the push cycle
  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input int mode);
    int fe0;
    logic ev;
    fe0 = fe_cnt;
    @(posedge clk);
    #1;
    uart_rx_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(CPB);
      uart_rx_in = d[i];
    end
    step(CPB);
    uart_rx_in = stop;
    if (mode == 0) begin
      step(CPB);
    end else begin
      step(CPB - 6);
      if (mode == 1) begin
        nvec++;
        if (rd_valid !== 1'b0) begin
          nerr++;
          $display("FAIL early_valid: got %b want 0",
                   rd_valid);
        end
      end else begin
        nvec++;
        if (rd_data !== q[0]) begin
          nerr++;
          $display("FAIL pp_head: got %h want %h",
                   rd_data, q[0]);
        end
        rd_en = 1'b1;
      end
      step(1);
      rd_en = 1'b0;
      if (mode == 1) begin
        nvec++;
        if (rd_valid !== 1'b1 || rd_data !== d) begin
          nerr++;
          $display("FAIL latency: got %b/%h want 1/%h",
                   rd_valid, rd_data, d);
        end
      end
      step(CPB - 11);
    end
    if (stop) begin
      if (mode == 2) begin
        void'(q.pop_front());
        exp_ovr = 1'b0;
        q.push_back(d);
      end else if (q.size() < 4) begin
        q.push_back(d);
      end else begin
        exp_ovr = 1'b1;
      end
    end
    nvec++;
    if (fe_cnt - fe0 != (stop ? 0 : 1)) begin
      nerr++;
      $display("FAIL frame_err_pulses: got %0d want %0d",
               fe_cnt - fe0, stop ? 0 : 1);
    end
    ev = (q.size() != 0);
    nvec++;
    if (rd_valid !== ev) begin
      nerr++;
      $display("FAIL rd_valid: got %b want %b",
               rd_valid, ev);
    end
    ev = (q.size() == 4);
    nvec++;
    if (fifo_full !== ev) begin
      nerr++;
      $display("FAIL fifo_full: got %b want %b",
               fifo_full, ev);
    end
    nvec++;
    if (overrun !== exp_ovr) begin
      nerr++;
      $display("FAIL overrun: got %b want %b",
               overrun, exp_ovr);
    end
    if (q.size() != 0) begin
      nvec++;
      if (rd_data !== q[0]) begin
        nerr++;
        $display("FAIL head: got %h want %h",
                 rd_data, q[0]);
      end
    end
  endtask

  task automatic pop_byte();
    logic ev;
    if (q.size() != 0) begin
      nvec++;
      if (rd_valid !== 1'b1 || rd_data !== q[0]) begin
        nerr++;
        $display("FAIL pop_data: got %b/%h want 1/%h",
                 rd_valid, rd_data, q[0]);
      end
    end
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    if (q.size() != 0) begin
      void'(q.pop_front());
      exp_ovr = 1'b0;
    end
    ev = (q.size() != 0);
    nvec++;
    if (rd_valid !== ev || overrun !== exp_ovr) begin
      nerr++;
      $display("FAIL after_pop: got v%b o%b want v%b o%b",
               rd_valid, overrun, ev, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst_pin    = 1'b1;
    uart_rx_in = 1'b1;
    rd_en      = 1'b0;
    step(3);
    rst_pin = 1'b0;
    step(1);
    nvec++;
    if (rd_valid !== 1'b0 || fifo_full !== 1'b0) begin
      nerr++;
      $display("FAIL reset_flags: got v%b f%b want 0 0",
               rd_valid, fifo_full);
    end
    nvec++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      nerr++;
      $display("FAIL reset_err: got e%b o%b want 0 0",
               frame_err, overrun);
    end
    nvec++;
    if (rd_data !== 8'h00) begin
      nerr++;
      $display("FAIL reset_data: got %h want 00", rd_data);
    end
  endtask

  task automatic test_basic();
    send_frame(8'h53, 1'b1, 1);
    pop_byte();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    uart_rx_in = 1'b0;
    step(4);
    uart_rx_in = 1'b1;
    step(3 * CPB);
    nvec++;
    if (rd_valid !== 1'b0 || fe_cnt != fe0) begin
      nerr++;
      $display("FAIL glitch: got v%b fe%0d want v0 fe0",
               rd_valid, fe_cnt - fe0);
    end
    send_frame(8'h3C, 1'b1, 1);
    pop_byte();
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h41, 1'b0, 0);
    step(3 * CPB);
    uart_rx_in = 1'b1;
    step(2 * CPB);
    nvec++;
    if (fe_cnt - fe0 != 1 || rd_valid !== 1'b0) begin
      nerr++;
      $display("FAIL break: got fe%0d v%b want fe1 v0",
               fe_cnt - fe0, rd_valid);
    end
    send_frame(8'h42, 1'b1, 1);
    pop_byte();
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      pop_byte();
    end
    pop_byte();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'hA5;
    send_frame(8'h77, 1'b1, 0);
    @(posedge clk);
    #1;
    uart_rx_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(CPB);
      uart_rx_in = b[i];
    end
    step(8);
    rst_pin    = 1'b1;
    uart_rx_in = 1'b1;
    step(1);
    rst_pin = 1'b0;
    q.delete();
    exp_ovr = 1'b0;
    nvec++;
    if ({rd_valid, fifo_full, frame_err, overrun}
        !== 4'b0000 || rd_data !== 8'h00) begin
      nerr++;
      $display("FAIL mid_reset: got %b%b%b%b/%h want 0000/00",
               rd_valid, fifo_full, frame_err, overrun,
               rd_data);
    end
    step(2 * CPB);
    nvec++;
    if (rd_valid !== 1'b0) begin
      nerr++;
      $display("FAIL partial_push: got %b want 0", rd_valid);
    end
    send_frame(8'hA5, 1'b1, 1);
    pop_byte();
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 0);
    end
    send_frame(8'h14, 1'b1, 2);
    for (int i = 0; i < 4; i++) begin
      pop_byte();
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       s;
    int         np;
    for (int it = 0; it < 30; it++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, s, 0);
      if (!s) begin
        step(CPB);
        uart_rx_in = 1'b1;
        step(CPB);
      end
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) begin
        pop_byte();
      end
    end
    while (q.size() != 0) pop_byte();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_full_pushpop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
